// File: rtl/pc_pkg.sv
// Shared fetch-path encodings: pcmux select codes, fetch sequencer states and
// the deferred-redirect latch. Also imported by pcmux and the CSR unit.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SRC_BOOT = 2'b00,
        PC_SRC_EPC  = 2'b01,
        PC_SRC_TRAP = 2'b10,
        PC_SRC_NEXT = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        S_BOOT = 2'b00,
        S_RUN  = 2'b01,
        S_WAIT = 2'b10
    } fetch_state_e;

    // Redirect captured while an AHB data phase is still in flight
    typedef struct packed {
        logic    valid;
        pc_src_e src;
    } pend_t;

    localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/pc_fetch_ctrl_wait_timer.sv
// AHB wait-state watchdog: counts consecutive stalled wait cycles and flags
// the cycle on which MAX_WAIT is reached. Instantiated only under FETCH_TIMEOUT_EN.
module fetch_wait_timer
    import pc_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic i_run,
    output logic o_hit
);

    localparam logic [WAIT_CNT_W-1:0] L_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

    logic [WAIT_CNT_W-1:0] r_cnt;

    assign o_hit = i_run && (r_cnt == L_LAST);

    // Restart on every hit so a wait that never ends keeps re-raising the timeout
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt <= '0;
        end else if (!i_run || o_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// RV32I fetch sequencer: owns the PC, drives the pcmux select, holds across AHB
// wait states and defers trap/mret redirects. Optional watchdog: FETCH_TIMEOUT_EN.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
    parameter int          MAX_WAIT     = 255
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        ahb_ready_in,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic        trap_taken_in,
    input  logic        mret_in,
    input  logic [31:0] pc_mux_in,
    input  logic        misaligned_instr_logic_in,
    output logic [31:0] pc_out,
    output logic [1:0]  pc_src_out,
    output logic        fetch_valid_out,
    output logic        flush_out,
    output logic        misaligned_trap_out,
    output logic        fetch_timeout_out
);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    pend_t        r_pend, w_pend_nxt;
    pc_src_e      w_src;
    logic         r_flush, w_flush_nxt;
    logic         r_mis, w_mis_nxt;
    logic         r_timeout;
    logic         w_tmo_hit;
    logic         w_redirect;
    logic         w_bad_target;
    logic         w_pend_trap;

    assign w_redirect   = trap_taken_in || mret_in || branch_taken_in;
    // A CSR redirect in the same cycle supersedes a misaligned branch target
    assign w_bad_target = branch_taken_in && misaligned_instr_logic_in &&
                          !trap_taken_in && !mret_in;
    assign w_pend_trap  = r_pend.valid && (r_pend.src == PC_SRC_TRAP);

`ifdef FETCH_TIMEOUT_EN
    fetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .i_run  ((r_state == S_WAIT) && !ahb_ready_in),
        .o_hit  (w_tmo_hit)
    );
`else
    // Watchdog absent: waits are unbounded (MAX_WAIT is never 0, so this is constant low)
    assign w_tmo_hit = (MAX_WAIT == 0);
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= S_BOOT;
            r_pc      <= BOOT_ADDRESS;
            r_pend    <= '0;
            r_flush   <= 1'b0;
            r_mis     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_pend    <= w_pend_nxt;
            r_flush   <= w_flush_nxt;
            r_mis     <= w_mis_nxt;
            r_timeout <= w_tmo_hit;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend;
        w_flush_nxt = 1'b0;
        w_mis_nxt   = 1'b0;
        w_src       = PC_SRC_NEXT;

        case (r_state)
            S_BOOT: begin
                w_src       = PC_SRC_BOOT;
                w_pc_nxt    = pc_mux_in;
                w_state_nxt = S_RUN;
            end

            S_RUN: begin
                if (trap_taken_in) begin
                    w_src = PC_SRC_TRAP;
                end else if (mret_in) begin
                    w_src = PC_SRC_EPC;
                end

                if (!ahb_ready_in) begin
                    w_state_nxt = S_WAIT;
                end else if (w_bad_target) begin
                    w_mis_nxt = 1'b1;
                end else if (!stall_in || w_redirect) begin
                    w_pc_nxt    = pc_mux_in;
                    w_flush_nxt = w_redirect;
                end
            end

            S_WAIT: begin
                if (r_pend.valid) begin
                    w_src = r_pend.src;
                end

                if (ahb_ready_in) begin
                    w_state_nxt = S_RUN;
                    if (r_pend.valid) begin
                        w_pc_nxt    = pc_mux_in;
                        w_flush_nxt = 1'b1;
                        w_pend_nxt  = '0;
                    end
                end else if (trap_taken_in || w_tmo_hit) begin
                    w_pend_nxt.valid = 1'b1;
                    w_pend_nxt.src   = PC_SRC_TRAP;
                end else if (mret_in && !w_pend_trap) begin
                    w_pend_nxt.valid = 1'b1;
                    w_pend_nxt.src   = PC_SRC_EPC;
                end
            end

            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign pc_out              = r_pc;
    assign pc_src_out          = w_src;
    assign fetch_valid_out     = ahb_ready_in && (r_state == S_RUN);
    assign flush_out           = r_flush;
    assign misaligned_trap_out = r_mis;
    assign fetch_timeout_out   = r_timeout;

endmodule
